// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 opcode, state and control-field encodings used by
//                the multi-cycle controller and the immediate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

   // Major opcodes (IR[6:0])
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_ALU_R  = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Controller state encoding (visible on the debug state port)
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Next-PC source
   localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_SRC_IMM   = 2'b01;
   localparam logic [1:0] PC_SRC_ALU   = 2'b10;

   // Register-file write-back source
   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // ALU operand A source
   localparam logic [1:0] ALU_A_RS1  = 2'b00;
   localparam logic [1:0] ALU_A_PC   = 2'b01;
   localparam logic [1:0] ALU_A_ZERO = 2'b10;

   // ALU operation class
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_CMP   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // One-hot instruction class produced by the opcode decoder
   typedef struct packed {
      logic alu_i;
      logic alu_r;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic lui;
      logic auipc;
      logic fence;
      logic system;
      logic illegal;
   } opclass_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_opclass.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_opclass
//  Description : Combinational opcode -> one-hot instruction class decoder.
//                Any opcode not in the supported set flags illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_opclass
   import rv32_pkg::*;
(
   input  logic [6:0] i_opcode,
   output opclass_t   o_cls
);

   // Classify the major opcode; exactly one class bit is set
   always_comb begin
      o_cls = '0;
      case (i_opcode)
         OP_ALU_I  : o_cls.alu_i  = 1'b1;
         OP_ALU_R  : o_cls.alu_r  = 1'b1;
         OP_LOAD   : o_cls.load   = 1'b1;
         OP_STORE  : o_cls.store  = 1'b1;
         OP_BRANCH : o_cls.branch = 1'b1;
         OP_JAL    : o_cls.jal    = 1'b1;
         OP_JALR   : o_cls.jalr   = 1'b1;
         OP_LUI    : o_cls.lui    = 1'b1;
         OP_AUIPC  : o_cls.auipc  = 1'b1;
         OP_FENCE  : o_cls.fence  = 1'b1;
         OP_SYSTEM : o_cls.system = 1'b1;
         default   : o_cls.illegal = 1'b1;
      endcase
   end

endmodule : rv32_opclass
`default_nettype wire

// File: rtl/rv32_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mc_ctrl
//  Description : Multi-cycle RV32 control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
//                Drives the shared memory port, IR/PC enables, ALU muxes and
//                register-file write; keeps instret and halt/illegal status.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_mc_ctrl
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  i_ir_opcode,
   input  logic        i_branch_taken,
   input  logic        i_mem_ack,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic        o_mem_addr_sel,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic [1:0]  o_pc_src,
   output logic [1:0]  o_alu_a_sel,
   output logic        o_alu_b_sel,
   output logic [1:0]  o_alu_op,
   output logic        o_rf_we,
   output logic [1:0]  o_wb_sel,
   output logic        o_halted,
   output logic        o_illegal,
   output logic [31:0] o_instret,
   output logic [2:0]  o_state
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instret;
   logic        r_halted;
   logic        r_illegal;
   opclass_t    w_cls;
   logic        w_retire;
   logic        w_enter_halt;
   logic        w_halt_illegal;

   rv32_opclass u_opclass (
      .i_opcode (i_ir_opcode),
      .o_cls    (w_cls)
   );

   // State, retire counter and sticky halt status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_FETCH;
         r_instret <= 32'd0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_instret <= r_instret + 32'd1;
         end
         if (w_enter_halt) begin
            r_halted  <= 1'b1;
            r_illegal <= w_halt_illegal;
         end
      end
   end

   // Next-state and control decode from state plus opcode class
   always_comb begin
      w_next         = r_state;
      w_retire       = 1'b0;
      w_enter_halt   = 1'b0;
      w_halt_illegal = 1'b0;
      o_mem_req      = 1'b0;
      o_mem_we       = 1'b0;
      o_mem_addr_sel = 1'b0;
      o_ir_we        = 1'b0;
      o_pc_we        = 1'b0;
      o_pc_src       = PC_SRC_PLUS4;
      o_alu_a_sel    = ALU_A_RS1;
      o_alu_b_sel    = 1'b0;
      o_alu_op       = ALU_OP_ADD;
      o_rf_we        = 1'b0;
      o_wb_sel       = WB_ALU;
      if (!rst) begin
         case (r_state)
            ST_FETCH: begin
               o_mem_req = 1'b1;
               if (i_mem_ack) begin
                  o_ir_we = 1'b1;
                  w_next  = ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (w_cls.fence) begin
                  w_retire = 1'b1;
               end else if (w_cls.system) begin
                  w_enter_halt = 1'b1;
               end else if (w_cls.illegal) begin
                  w_enter_halt   = 1'b1;
                  w_halt_illegal = 1'b1;
               end else begin
                  w_next = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (w_cls.lui) begin
                  o_alu_a_sel = ALU_A_ZERO;
                  o_alu_b_sel = 1'b1;
               end else if (w_cls.auipc) begin
                  o_alu_a_sel = ALU_A_PC;
                  o_alu_b_sel = 1'b1;
               end else if (w_cls.alu_i) begin
                  o_alu_b_sel = 1'b1;
                  o_alu_op    = ALU_OP_FUNCT;
               end else if (w_cls.alu_r) begin
                  o_alu_op    = ALU_OP_FUNCT;
               end else if (w_cls.load || w_cls.store || w_cls.jalr) begin
                  o_alu_b_sel = 1'b1;
               end else if (w_cls.branch) begin
                  o_alu_op    = ALU_OP_CMP;
               end
               if (w_cls.branch) begin
                  w_retire = 1'b1;
                  o_pc_src = i_branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
               end else if (w_cls.load || w_cls.store) begin
                  w_next = ST_MEM;
               end else begin
                  w_next = ST_WB;
               end
            end
            ST_MEM: begin
               o_mem_req      = 1'b1;
               o_mem_addr_sel = 1'b1;
               o_mem_we       = w_cls.store;
               if (i_mem_ack) begin
                  if (w_cls.store) begin
                     w_retire = 1'b1;
                  end else begin
                     w_next = ST_WB;
                  end
               end
            end
            ST_WB: begin
               o_rf_we  = 1'b1;
               w_retire = 1'b1;
               if (w_cls.load) begin
                  o_wb_sel = WB_MEM;
               end else if (w_cls.jal || w_cls.jalr) begin
                  o_wb_sel = WB_PC4;
               end
               if (w_cls.jal) begin
                  o_pc_src = PC_SRC_IMM;
               end else if (w_cls.jalr) begin
                  o_pc_src = PC_SRC_ALU;
               end
            end
            ST_HALT: begin
               w_next = ST_HALT;
            end
            default: begin
               w_next = ST_FETCH;
            end
         endcase
         // Retire always updates the PC and returns to FETCH
         if (w_retire) begin
            o_pc_we = 1'b1;
            w_next  = ST_FETCH;
         end
         if (w_enter_halt) begin
            w_next = ST_HALT;
         end
      end
   end

   // Status outputs, forced to 0 during reset
   always_comb begin
      o_halted  = rst ? 1'b0  : r_halted;
      o_illegal = rst ? 1'b0  : r_illegal;
      o_instret = rst ? 32'd0 : r_instret;
      o_state   = rst ? 3'd0  : r_state;
   end

endmodule : rv32_mc_ctrl
`default_nettype wire

// File: tb/tb_rv32_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_mc_ctrl
//  Description : Directed self-checking bench for the multi-cycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_mc_ctrl;

   logic        clk;
   logic        rst;
   logic [6:0]  r_op;
   logic        r_bt;
   logic        r_ack;
   logic        w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_we, w_pc_we;
   logic [1:0]  w_pc_src, w_alu_a_sel, w_alu_op, w_wb_sel;
   logic        w_alu_b_sel, w_rf_we, w_halted, w_illegal;
   logic [31:0] w_instret;
   logic [2:0]  w_state;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] C_ADDI = 7'b0010011;
   localparam logic [6:0] C_LW   = 7'b0000011;
   localparam logic [6:0] C_SW   = 7'b0100011;
   localparam logic [6:0] C_BEQ  = 7'b1100011;
   localparam logic [6:0] C_JALR = 7'b1100111;
   localparam logic [6:0] C_JAL  = 7'b1101111;
   localparam logic [6:0] C_LUI  = 7'b0110111;
   localparam logic [6:0] C_FENC = 7'b0001111;
   localparam logic [6:0] C_ECAL = 7'b1110011;
   localparam logic [6:0] C_BAD  = 7'b0000000;

   rv32_mc_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .i_ir_opcode    (r_op),
      .i_branch_taken (r_bt),
      .i_mem_ack      (r_ack),
      .o_mem_req      (w_mem_req),
      .o_mem_we       (w_mem_we),
      .o_mem_addr_sel (w_mem_addr_sel),
      .o_ir_we        (w_ir_we),
      .o_pc_we        (w_pc_we),
      .o_pc_src       (w_pc_src),
      .o_alu_a_sel    (w_alu_a_sel),
      .o_alu_b_sel    (w_alu_b_sel),
      .o_alu_op       (w_alu_op),
      .o_rf_we        (w_rf_we),
      .o_wb_sel       (w_wb_sel),
      .o_halted       (w_halted),
      .o_illegal      (w_illegal),
      .o_instret      (w_instret),
      .o_state        (w_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench
   task automatic t_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected control word: req,we,addr_sel,ir_we,pc_we,pc_src,a,b,op,rf_we,wb
   function automatic logic [31:0] f_ctl(input logic req, input logic we, input logic asel,
                                         input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                         input logic [1:0] a, input logic b, input logic [1:0] op,
                                         input logic rfwe, input logic [1:0] wb);
      return {16'd0, req, we, asel, irwe, pcwe, pcs, a, b, op, rfwe, wb};
   endfunction

   function automatic logic [31:0] f_obs();
      return {16'd0, w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_we, w_pc_we, w_pc_src,
              w_alu_a_sel, w_alu_b_sel, w_alu_op, w_rf_we, w_wb_sel};
   endfunction

   // Apply inputs on the falling edge; outputs are sampled 1 ns later
   task automatic t_drive(input logic rs, input logic [6:0] op, input logic ack, input logic bt);
      @(negedge clk);
      rst   = rs;
      r_op  = op;
      r_ack = ack;
      r_bt  = bt;
      #1;
   endtask

   // Drive one cycle and check state plus full control word
   task automatic t_cyc(input string tag, input logic [6:0] op, input logic ack, input logic bt,
                        input logic [2:0] st, input logic [31:0] ctl);
      t_drive(1'b0, op, ack, bt);
      t_check({tag, ".state"}, {29'd0, w_state}, {29'd0, st});
      t_check({tag, ".ctl"}, f_obs(), ctl);
   endtask

   localparam logic [31:0] C_IDLE = 32'd0;

   initial begin
      rst = 1'b1; r_op = C_ADDI; r_ack = 1'b0; r_bt = 1'b0;
      t_drive(1'b1, C_ADDI, 1'b0, 1'b0);
      t_drive(1'b1, C_ADDI, 1'b0, 1'b0);
      t_check("rst.ctl", f_obs(), C_IDLE);
      t_check("rst.stat", {29'd0, w_state, w_halted, w_illegal} , 32'd0);

      // ADDI, immediate ack: 0,1,2,4
      t_cyc("addi.f", C_ADDI, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("addi.ir0", w_instret, 32'd0);
      t_cyc("addi.d", C_ADDI, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("addi.e", C_ADDI, 1'b0, 1'b0, 3'd2, f_ctl(0,0,0,0,0,2'd0,2'd0,1,2'd2,0,2'd0));
      t_cyc("addi.w", C_ADDI, 1'b0, 1'b0, 3'd4, f_ctl(0,0,0,0,1,2'd0,2'd0,0,2'd0,1,2'd0));
      t_check("addi.ir1", w_instret, 32'd0);

      // LW, fetch ack after 2 waits, MEM ack after 1 wait: 8 cycles
      t_cyc("lw.f0", C_LW, 1'b0, 1'b0, 3'd0, f_ctl(1,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("lw.ir", w_instret, 32'd1);
      t_cyc("lw.f1", C_LW, 1'b0, 1'b0, 3'd0, f_ctl(1,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("lw.f2", C_LW, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("lw.d", C_LW, 1'b1, 1'b0, 3'd1, C_IDLE);
      t_cyc("lw.e", C_LW, 1'b1, 1'b0, 3'd2, f_ctl(0,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd0));
      t_cyc("lw.m0", C_LW, 1'b0, 1'b0, 3'd3, f_ctl(1,0,1,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("lw.m1", C_LW, 1'b1, 1'b0, 3'd3, f_ctl(1,0,1,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("lw.w", C_LW, 1'b1, 1'b0, 3'd4, f_ctl(0,0,0,0,1,2'd0,2'd0,0,2'd0,1,2'd1));

      // BEQ taken, then not taken
      t_cyc("beq1.f", C_BEQ, 1'b1, 1'b1, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("beq1.ir", w_instret, 32'd2);
      t_cyc("beq1.d", C_BEQ, 1'b0, 1'b1, 3'd1, C_IDLE);
      t_cyc("beq1.e", C_BEQ, 1'b0, 1'b1, 3'd2, f_ctl(0,0,0,0,1,2'd1,2'd0,0,2'd1,0,2'd0));
      t_cyc("beq0.f", C_BEQ, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("beq0.ir", w_instret, 32'd3);
      t_cyc("beq0.d", C_BEQ, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("beq0.e", C_BEQ, 1'b0, 1'b0, 3'd2, f_ctl(0,0,0,0,1,2'd0,2'd0,0,2'd1,0,2'd0));

      // JALR
      t_cyc("jalr.f", C_JALR, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("jalr.ir", w_instret, 32'd4);
      t_cyc("jalr.d", C_JALR, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("jalr.e", C_JALR, 1'b0, 1'b0, 3'd2, f_ctl(0,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd0));
      t_cyc("jalr.w", C_JALR, 1'b0, 1'b0, 3'd4, f_ctl(0,0,0,0,1,2'd2,2'd0,0,2'd0,1,2'd2));

      // FENCE retires in DECODE (2 cycles)
      t_cyc("fence.f", C_FENC, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("fence.d", C_FENC, 1'b0, 1'b0, 3'd1, f_ctl(0,0,0,0,1,2'd0,2'd0,0,2'd0,0,2'd0));

      // LUI then JAL
      t_cyc("lui.f", C_LUI, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("lui.ir", w_instret, 32'd6);
      t_cyc("lui.d", C_LUI, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("lui.e", C_LUI, 1'b0, 1'b0, 3'd2, f_ctl(0,0,0,0,0,2'd0,2'd2,1,2'd0,0,2'd0));
      t_cyc("lui.w", C_LUI, 1'b0, 1'b0, 3'd4, f_ctl(0,0,0,0,1,2'd0,2'd0,0,2'd0,1,2'd0));
      t_cyc("jal.f", C_JAL, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("jal.d", C_JAL, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("jal.e", C_JAL, 1'b0, 1'b0, 3'd2, C_IDLE);
      t_cyc("jal.w", C_JAL, 1'b0, 1'b0, 3'd4, f_ctl(0,0,0,0,1,2'd1,2'd0,0,2'd0,1,2'd2));

      // Illegal opcode -> HALT with illegal; ack pulses ignored
      t_cyc("bad.f", C_BAD, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("bad.ir", w_instret, 32'd8);
      t_cyc("bad.d", C_BAD, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_check("bad.hd0", {31'd0, w_halted}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         t_cyc("bad.h", C_BAD, i[0] ? 1'b0 : 1'b1, 1'b0, 3'd5, C_IDLE);
         t_check("bad.hi", {30'd0, w_halted, w_illegal}, 32'd3);
         t_check("bad.hir", w_instret, 32'd8);
      end
      t_drive(1'b1, C_BAD, 1'b0, 1'b0);
      t_check("badrst.stat", {29'd0, w_state, w_halted, w_illegal}, 32'd0);
      t_check("badrst.ir", w_instret, 32'd0);

      // ECALL -> HALT without illegal
      t_cyc("ecall.f", C_ECAL, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_cyc("ecall.d", C_ECAL, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("ecall.h", C_ECAL, 1'b1, 1'b0, 3'd5, C_IDLE);
      t_check("ecall.hi", {30'd0, w_halted, w_illegal}, 32'd2);
      t_drive(1'b1, C_ECAL, 1'b0, 1'b0);

      // SW aborted by reset during MEM
      t_cyc("sw.f", C_SW, 1'b1, 1'b0, 3'd0, f_ctl(1,0,0,1,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("sw.ir", w_instret, 32'd0);
      t_cyc("sw.d", C_SW, 1'b0, 1'b0, 3'd1, C_IDLE);
      t_cyc("sw.e", C_SW, 1'b0, 1'b0, 3'd2, f_ctl(0,0,0,0,0,2'd0,2'd0,1,2'd0,0,2'd0));
      t_cyc("sw.m", C_SW, 1'b0, 1'b0, 3'd3, f_ctl(1,1,1,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_drive(1'b1, C_SW, 1'b1, 1'b0);
      t_check("swrst.ctl", f_obs(), C_IDLE);
      t_check("swrst.st", {29'd0, w_state}, 32'd0);
      t_cyc("swpost.f", C_SW, 1'b0, 1'b0, 3'd0, f_ctl(1,0,0,0,0,2'd0,2'd0,0,2'd0,0,2'd0));
      t_check("swpost.ir", w_instret, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rv32_mc_ctrl
`default_nettype wire
